// File: rtl/vsync_edge_capture.sv
// Camera vsync front end: synchronises vsync into the clk domain, flags its edges,
// latches a data word on the selected edge and gates frame capture with a small FSM.
module vsync_edge_capture #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vsync_sync,
  output logic             rise_pulse,
  output logic             fall_pulse,
  input  logic             capture_req,
  input  logic             continuous,
  input  logic             abort,
  output logic             frame_active,
  output logic             done,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   hist;
  logic                   rise_cond;
  logic                   fall_cond;
  logic                   load_cond;

  assign vsync_sync = sync_ff[SYNC_STAGES-1];
  assign rise_cond  = vsync_sync & ~hist;
  assign fall_cond  = ~vsync_sync & hist;

  always_comb begin
    load_cond = fall_cond;
    case (EDGE_MODE)
      0:       load_cond = fall_cond;
      1:       load_cond = rise_cond;
      default: load_cond = rise_cond | fall_cond;
    endcase
  end

  // Everything resets to the idle-high vsync level so no edge appears on release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_ff    <= '1;
      hist       <= 1'b1;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_ff    <= {sync_ff[SYNC_STAGES-2:0], vsync_in};
      hist       <= vsync_sync;
      rise_pulse <= rise_cond;
      fall_pulse <= fall_cond;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load_cond) begin
      q <= d;
    end
  end

  // abort outranks every other input; ARMED only leaves on a true falling edge,
  // so arming mid-frame waits for the next frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      frame_active <= 1'b0;
      done         <= 1'b0;
      frame_count  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state        <= IDLE;
        frame_active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (capture_req) begin
              state <= ARMED;
            end
          end
          ARMED: begin
            if (fall_cond) begin
              state        <= CAPTURE;
              frame_active <= 1'b1;
            end
          end
          CAPTURE: begin
            if (rise_cond) begin
              frame_active <= 1'b0;
              done         <= 1'b1;
              frame_count  <= frame_count + CNT_W'(1);
              state        <= continuous ? ARMED : IDLE;
            end
          end
          default: begin
            state        <= IDLE;
            frame_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vsync_edge_capture.sv
// Directed bench for vsync_edge_capture: two instances share stimulus, one falling-edge
// latch with an 8-bit count, one both-edge latch with a 2-bit count for wrap checks.
module tb_vsync_edge_capture;

  logic       clk;
  logic       rst_n;
  logic       vsync_in;
  logic [7:0] d;
  logic       capture_req;
  logic       continuous;
  logic       abort;

  logic [7:0] q0, q1;
  logic       vs0, vs1, rise0, rise1, fall0, fall1;
  logic       active0, active1, done0, done1;
  logic [7:0] fc0;
  logic [1:0] fc1;

  int checks;
  int failures;
  int n_done0, n_rise0, n_fall0, n_active0, n_done1;

  vsync_edge_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in), .d(d), .q(q0),
    .vsync_sync(vs0), .rise_pulse(rise0), .fall_pulse(fall0),
    .capture_req(capture_req), .continuous(continuous), .abort(abort),
    .frame_active(active0), .done(done0), .frame_count(fc0)
  );

  vsync_edge_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in), .d(d), .q(q1),
    .vsync_sync(vs1), .rise_pulse(rise1), .fall_pulse(fall1),
    .capture_req(capture_req), .continuous(continuous), .abort(abort),
    .frame_active(active1), .done(done1), .frame_count(fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies sampled mid-cycle, used to prove "exactly one" / "none" over a window
  always @(negedge clk) begin
    if (done0)   n_done0++;
    if (rise0)   n_rise0++;
    if (fall0)   n_fall0++;
    if (active0) n_active0++;
    if (done1)   n_done1++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; vsync_in = 1'b1; capture_req = 1'b0;
    continuous = 1'b0; abort = 1'b0; d = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    int sd, sr, sf;
    rst_n = 1'b0; vsync_in = 1'b0; capture_req = 1'b1;
    continuous = 1'b0; abort = 1'b0; d = 8'hFF;
    tick(3);
    checks++; if (vs0 !== 1'b1) begin failures++; $display("[TB] FAIL reset_vsync_sync: got %0b expected 1", vs0); end
    checks++; if (q0 !== 8'h00) begin failures++; $display("[TB] FAIL reset_q: got %0h expected 00", q0); end
    checks++; if (fc0 !== 8'h00) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", fc0); end
    checks++; if (active0 !== 1'b0 || done0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_active_done: got %0b%0b expected 00", active0, done0); end
    vsync_in = 1'b1; capture_req = 1'b0;
    tick(1);
    rst_n = 1'b1;
    sd = n_done0; sr = n_rise0; sf = n_fall0;
    tick(20);
    checks++; if (n_rise0 - sr !== 0 || n_fall0 - sf !== 0) begin failures++; $display("[TB] FAIL reset_no_edges: got rise=%0d fall=%0d expected 0 0", n_rise0 - sr, n_fall0 - sf); end
    checks++; if (n_done0 - sd !== 0) begin failures++; $display("[TB] FAIL reset_no_done: got %0d expected 0", n_done0 - sd); end
    checks++; if (q0 !== 8'h00 || fc0 !== 8'h00) begin failures++; $display("[TB] FAIL reset_hold: got q=%0h count=%0d expected 00 0", q0, fc0); end
    vsync_in = 1'b0;
    tick(3);
    checks++; if (active0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_ignored: got %0b expected 0", active0); end
    vsync_in = 1'b1;
    tick(5);
  endtask

  task automatic test_edge_latency();
    reset_dut();
    d = 8'hA5;
    vsync_in = 1'b0;
    tick(1);
    checks++; if (fall0 !== 1'b0) begin failures++; $display("[TB] FAIL fall_early1: got %0b expected 0", fall0); end
    tick(1);
    checks++; if (fall0 !== 1'b0 || vs0 !== 1'b0) begin failures++; $display("[TB] FAIL fall_early2: got fall=%0b vsync_sync=%0b expected 0 0", fall0, vs0); end
    tick(1);
    checks++; if (fall0 !== 1'b1) begin failures++; $display("[TB] FAIL fall_pulse: got %0b expected 1", fall0); end
    checks++; if (q0 !== 8'hA5) begin failures++; $display("[TB] FAIL fall_latch: got %0h expected a5", q0); end
    tick(1);
    checks++; if (fall0 !== 1'b0) begin failures++; $display("[TB] FAIL fall_one_cycle: got %0b expected 0", fall0); end
    d = 8'h5A;
    tick(5);
    vsync_in = 1'b1;
    tick(2);
    checks++; if (rise0 !== 1'b0) begin failures++; $display("[TB] FAIL rise_early: got %0b expected 0", rise0); end
    tick(1);
    checks++; if (rise0 !== 1'b1 || fall0 !== 1'b0) begin failures++; $display("[TB] FAIL rise_pulse: got rise=%0b fall=%0b expected 1 0", rise0, fall0); end
    checks++; if (q0 !== 8'hA5) begin failures++; $display("[TB] FAIL rise_no_latch: got %0h expected a5", q0); end
    tick(1);
    checks++; if (rise0 !== 1'b0) begin failures++; $display("[TB] FAIL rise_one_cycle: got %0b expected 0", rise0); end
  endtask

  task automatic test_single_capture();
    int sd, sa;
    reset_dut();
    capture_req = 1'b1; tick(1); capture_req = 1'b0;
    tick(5);
    sa = n_active0; sd = n_done0;
    vsync_in = 1'b0;
    tick(2);
    checks++; if (active0 !== 1'b0) begin failures++; $display("[TB] FAIL cap_not_yet: got %0b expected 0", active0); end
    tick(1);
    checks++; if (active0 !== 1'b1 || fall0 !== 1'b1) begin failures++; $display("[TB] FAIL cap_start: got active=%0b fall=%0b expected 1 1", active0, fall0); end
    tick(100);
    vsync_in = 1'b1;
    tick(2);
    checks++; if (active0 !== 1'b1 || done0 !== 1'b0) begin failures++; $display("[TB] FAIL cap_mid: got active=%0b done=%0b expected 1 0", active0, done0); end
    tick(1);
    checks++; if (rise0 !== 1'b1 || done0 !== 1'b1 || active0 !== 1'b0) begin failures++; $display("[TB] FAIL cap_end: got rise=%0b done=%0b active=%0b expected 1 1 0", rise0, done0, active0); end
    checks++; if (fc0 !== 8'd1) begin failures++; $display("[TB] FAIL cap_count: got %0d expected 1", fc0); end
    checks++; if (n_active0 - sa !== 103) begin failures++; $display("[TB] FAIL cap_active_len: got %0d expected 103", n_active0 - sa); end
    tick(1);
    checks++; if (done0 !== 1'b0) begin failures++; $display("[TB] FAIL cap_done_one_cycle: got %0b expected 0", done0); end
    vsync_in = 1'b0; tick(20);
    checks++; if (active0 !== 1'b0) begin failures++; $display("[TB] FAIL cap_second_active: got %0b expected 0", active0); end
    vsync_in = 1'b1; tick(5);
    checks++; if (n_done0 - sd !== 1 || fc0 !== 8'd1) begin failures++; $display("[TB] FAIL cap_second_done: got dones=%0d count=%0d expected 1 1", n_done0 - sd, fc0); end
  endtask

  task automatic test_continuous();
    int sd;
    reset_dut();
    continuous = 1'b1;
    capture_req = 1'b1; tick(1); capture_req = 1'b0;
    sd = n_done0;
    for (int i = 0; i < 3; i++) begin
      vsync_in = 1'b0; tick(3);
      checks++; if (active0 !== 1'b1) begin failures++; $display("[TB] FAIL cont_active_%0d: got %0b expected 1", i, active0); end
      tick(10);
      vsync_in = 1'b1; tick(3);
      checks++; if (done0 !== 1'b1) begin failures++; $display("[TB] FAIL cont_done_%0d: got %0b expected 1", i, done0); end
      tick(10);
    end
    checks++; if (n_done0 - sd !== 3 || fc0 !== 8'd3) begin failures++; $display("[TB] FAIL cont_total: got dones=%0d count=%0d expected 3 3", n_done0 - sd, fc0); end
    continuous = 1'b0;
  endtask

  task automatic test_mid_frame_arm();
    reset_dut();
    vsync_in = 1'b0; tick(5);
    capture_req = 1'b1; tick(1); capture_req = 1'b0;
    tick(5);
    checks++; if (active0 !== 1'b0) begin failures++; $display("[TB] FAIL mid_no_partial: got %0b expected 0", active0); end
    vsync_in = 1'b1; tick(3);
    checks++; if (rise0 !== 1'b1 || done0 !== 1'b0) begin failures++; $display("[TB] FAIL mid_partial_end: got rise=%0b done=%0b expected 1 0", rise0, done0); end
    tick(5);
    vsync_in = 1'b0; tick(2);
    checks++; if (active0 !== 1'b0) begin failures++; $display("[TB] FAIL mid_pre_fall: got %0b expected 0", active0); end
    tick(1);
    checks++; if (active0 !== 1'b1) begin failures++; $display("[TB] FAIL mid_start: got %0b expected 1", active0); end
    tick(10);
    vsync_in = 1'b1; tick(3);
    checks++; if (done0 !== 1'b1 || fc0 !== 8'd1) begin failures++; $display("[TB] FAIL mid_done: got done=%0b count=%0d expected 1 1", done0, fc0); end
    tick(5);
  endtask

  task automatic test_arm_on_edge();
    reset_dut();
    vsync_in = 1'b0; tick(2);
    capture_req = 1'b1; tick(1); capture_req = 1'b0;
    checks++; if (fall0 !== 1'b1 || active0 !== 1'b0) begin failures++; $display("[TB] FAIL edgearm_same: got fall=%0b active=%0b expected 1 0", fall0, active0); end
    tick(5);
    vsync_in = 1'b1; tick(3);
    checks++; if (done0 !== 1'b0) begin failures++; $display("[TB] FAIL edgearm_no_done: got %0b expected 0", done0); end
    tick(5);
    vsync_in = 1'b0; tick(3);
    checks++; if (active0 !== 1'b1) begin failures++; $display("[TB] FAIL edgearm_next: got %0b expected 1", active0); end
    tick(5);
    vsync_in = 1'b1; tick(3);
    checks++; if (done0 !== 1'b1 || fc0 !== 8'd1) begin failures++; $display("[TB] FAIL edgearm_done: got done=%0b count=%0d expected 1 1", done0, fc0); end
    tick(5);
  endtask

  task automatic test_abort();
    int sd;
    reset_dut();
    capture_req = 1'b1; tick(1); capture_req = 1'b0;
    tick(3);
    vsync_in = 1'b0; tick(3);
    tick(49);
    sd = n_done0;
    abort = 1'b1; tick(1); abort = 1'b0;
    checks++; if (active0 !== 1'b0) begin failures++; $display("[TB] FAIL abort_drop: got %0b expected 0", active0); end
    tick(10);
    vsync_in = 1'b1; tick(3);
    checks++; if (rise0 !== 1'b1 || done0 !== 1'b0) begin failures++; $display("[TB] FAIL abort_no_done: got rise=%0b done=%0b expected 1 0", rise0, done0); end
    tick(3);
    checks++; if (fc0 !== 8'd0 || n_done0 - sd !== 0) begin failures++; $display("[TB] FAIL abort_count: got count=%0d dones=%0d expected 0 0", fc0, n_done0 - sd); end
    abort = 1'b1; capture_req = 1'b1; tick(1);
    abort = 1'b0; capture_req = 1'b0;
    tick(5);
    vsync_in = 1'b0; tick(3);
    checks++; if (active0 !== 1'b0) begin failures++; $display("[TB] FAIL abort_beats_req: got %0b expected 0", active0); end
    vsync_in = 1'b1; tick(5);
  endtask

  task automatic test_wrap_and_modes();
    logic [1:0] wrap_exp [5];
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
    reset_dut();
    d = 8'h3C;
    vsync_in = 1'b0; tick(3);
    checks++; if (q1 !== 8'h3C || q0 !== 8'h3C) begin failures++; $display("[TB] FAIL both_fall: got q1=%0h q0=%0h expected 3c 3c", q1, q0); end
    d = 8'hC3;
    tick(5);
    vsync_in = 1'b1; tick(2);
    checks++; if (q1 !== 8'h3C) begin failures++; $display("[TB] FAIL both_hold: got %0h expected 3c", q1); end
    tick(1);
    checks++; if (q1 !== 8'hC3 || q0 !== 8'h3C) begin failures++; $display("[TB] FAIL both_rise: got q1=%0h q0=%0h expected c3 3c", q1, q0); end
    tick(5);
    continuous = 1'b1;
    capture_req = 1'b1; tick(1); capture_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vsync_in = 1'b0; tick(3);
      tick(5);
      vsync_in = 1'b1; tick(3);
      checks++; if (done1 !== 1'b1 || fc1 !== wrap_exp[i]) begin failures++; $display("[TB] FAIL wrap_%0d: got done=%0b count=%0d expected 1 %0d", i, done1, fc1, wrap_exp[i]); end
      tick(5);
    end
    checks++; if (fc0 !== 8'd5) begin failures++; $display("[TB] FAIL wrap_wide_count: got %0d expected 5", fc0); end
    continuous = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    n_done0 = 0; n_rise0 = 0; n_fall0 = 0; n_active0 = 0; n_done1 = 0;
    rst_n = 1'b0; vsync_in = 1'b1; d = 8'h00;
    capture_req = 1'b0; continuous = 1'b0; abort = 1'b0;
    test_reset();
    test_edge_latency();
    test_single_capture();
    test_continuous();
    test_mid_frame_arm();
    test_arm_on_edge();
    test_abort();
    test_wrap_and_modes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
